// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern transmitter:
//   state_t              - transmitter FSM states (IDLE, SEND, FINISH)
//   SEQ_DEFAULT_PATTERN  - reference pattern used by the team's 1001 detector
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1001;

endpackage : seq_pkg

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Serialises a PAT_W-bit pattern MSB first, repeated repeat_cnt times. When
// overlap is requested and the pattern's MSB equals its LSB, repetitions
// 2..R reuse the previous LSB as their MSB and skip it.
//
// Optional feature (macro SEQ_TX_PARITY_EN): each repetition is followed by
// one even-parity bit of the pattern, and bit sharing is disabled.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   begin a transmission (sampled only in IDLE)
//   pattern    in   PAT_W-bit pattern, sent MSB first
//   repeat_cnt in   number of repetitions (0 = no bits, done only)
//   overlap    in   allow shared MSB/LSB between repetitions
//   outbit     out  serial data, 0 whenever out_valid is low
//   out_valid  out  outbit carries a transmitted bit
//   busy       out  high from capture through the last bit
//   done       out  one-cycle pulse when a transmission ends
// ---------------------------------------------------------------------------
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             overlap,
    output logic             outbit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_SHARE = IDX_W'(PAT_W - 2);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;     // index of the bit currently on outbit
    logic [CNT_W-1:0] rep_q, rep_d;     // repetitions still to start after this one
    logic             share_q, share_d;
    logic             outbit_q, outbit_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQ_TX_PARITY_EN
    logic             par_q, par_d;     // parity bit of this repetition is on outbit

    function automatic logic even_parity(input logic [PAT_W-1:0] p);
        return ^p;
    endfunction
`endif

    // Sharing needs equal end bits; the parity bit between repetitions breaks it.
    function automatic logic share_cond(input logic [PAT_W-1:0] p, input logic ov);
`ifdef SEQ_TX_PARITY_EN
        return 1'b0 & ov & (p[PAT_W-1] ~^ p[0]);
`else
        return ov & (p[PAT_W-1] ~^ p[0]);
`endif
    endfunction

    // Next-state, counters and next registered outputs.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        idx_d       = idx_q;
        rep_d       = rep_q;
        share_d     = share_q;
        outbit_d    = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    share_d = share_cond(pattern, overlap);
`ifdef SEQ_TX_PARITY_EN
                    par_d   = 1'b0;
`endif
                    if (repeat_cnt == {CNT_W{1'b0}}) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = SEND;
                        idx_d       = IDX_TOP;
                        rep_d       = repeat_cnt - 1'b1;
                        outbit_d    = pattern[PAT_W-1];
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (idx_q != {IDX_W{1'b0}}) begin
                    idx_d       = idx_q - 1'b1;
                    outbit_d    = pat_q[idx_d];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                end else if (!par_q) begin
                    par_d       = 1'b1;
                    outbit_d    = even_parity(pat_q);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
`endif
                end else if (rep_q != {CNT_W{1'b0}}) begin
                    // Start the next repetition, skipping its MSB when shared.
                    rep_d       = rep_q - 1'b1;
                    idx_d       = share_q ? IDX_SHARE : IDX_TOP;
                    outbit_d    = pat_q[idx_d];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                    par_d       = 1'b0;
`endif
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= {PAT_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            rep_q       <= {CNT_W{1'b0}};
            share_q     <= 1'b0;
            outbit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            idx_q       <= idx_d;
            rep_q       <= rep_d;
            share_q     <= share_d;
            outbit_q    <= outbit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SEQ_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign outbit    = outbit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : seq_pattern_tx

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern width in bits (2 to 8).
REQ-002 SHALL have parameter CNT_W, default 4, repetition-count width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, request to begin a transmission.
REQ-006 SHALL have port pattern, input, PAT_W bits, pattern to send, MSB first.
REQ-007 SHALL have port repeat_cnt, input, CNT_W bits, number of pattern repetitions.
REQ-008 SHALL have port overlap, input, 1 bit, enables overlapping (shared-bit) repetitions.
REQ-009 SHALL have port outbit, output, 1 bit, serial data, registered.
REQ-010 SHALL have port out_valid, output, 1 bit, high while outbit carries a transmitted bit.
REQ-011 SHALL have port busy, output, 1 bit, high from capture until the last bit.
REQ-012 SHALL have port done, output, 1 bit, one-cycle pulse when a transmission ends.

Function
REQ-013 SHALL implement states IDLE, SEND and FINISH.
REQ-014 In IDLE, start=1 SHALL capture pattern, repeat_cnt and overlap, and SHALL set busy=1 on the next edge.
REQ-015 SHALL present the first bit on outbit with out_valid=1 in the cycle after capture (latency 1), then one bit per cycle with no gaps.
REQ-016 The share condition SHALL be overlap=1 and pattern[PAT_W-1]==pattern[0].
REQ-017 When the share condition holds, repetitions 2..R SHALL omit their MSB, giving R*PAT_W-(R-1) bits in total.
REQ-018 When the share condition does not hold, the block SHALL send R*PAT_W bits.
REQ-019 After the last bit, the block SHALL enter FINISH for one cycle: done=1, busy=0, out_valid=0, outbit=0; it then returns to IDLE.
REQ-020 repeat_cnt=0 SHALL send no bits: FINISH follows capture directly, with done one cycle after capture.
REQ-021 start SHALL be ignored while busy=1 or in FINISH; inputs other than start SHALL be don't-care outside the capture cycle.
REQ-022 While out_valid=0, outbit SHALL be 0.
REQ-023 The repetition and bit counters SHALL count down without wrap; repeat_cnt at its maximum value SHALL send exactly that many repetitions.

Reset
REQ-024 When reset=1 on a clock edge, the block SHALL go to IDLE with outbit=0, out_valid=0, busy=0 and done=0.
REQ-025 A reset mid-transmission SHALL abort immediately, with no done pulse.
REQ-026 If reset and start are both high, reset SHALL win.

Configuration
REQ-027 With macro SEQ_TX_PARITY_EN defined, each repetition SHALL be followed by one even-parity bit of pattern, with out_valid=1.
REQ-028 With SEQ_TX_PARITY_EN defined, the share condition SHALL be forced false.
REQ-029 Without SEQ_TX_PARITY_EN, no parity logic SHALL be present and REQ-016 to REQ-018 SHALL apply unchanged.

Structure
REQ-030 Package seq_pkg SHALL hold the state enum (IDLE, SEND, FINISH) and the constant SEQ_DEFAULT_PATTERN = 4'b1001.
REQ-031 The design SHALL be a single module with no sub-module; the counters and shifter are inline.

Verification
REQ-032 pattern=1001, repeat_cnt=3, overlap=1 -> outbit sequence 1001001001 (10 valid cycles), then done on cycle 11 after capture.
REQ-033 pattern=1001, repeat_cnt=3, overlap=0 -> 100110011001 (12 valid cycles), then done.
REQ-034 pattern=1100, repeat_cnt=2, overlap=1 -> 11001100 with no sharing (8 bits).
REQ-035 Loopback into the team's 1001 overlapping Mealy detector with REQ-032 stimulus -> detect pulses exactly 3 times, aligned with valid bits 4, 7 and 10.
REQ-036 Reset asserted at valid bit 5 of REQ-032 -> all outputs 0 next cycle and no done pulse; a new start then produces the full sequence.
REQ-037 repeat_cnt=0 -> done one cycle after capture and out_valid never high; start pulsed during busy -> no effect on the sequence.
